picorv32_ahb_master: RTL and testbench
======================================

Name: picorv32_ahb_master

Overview:
- Single-outstanding AMBA2 AHB master for the GRLIB AHB bus; sits directly downstream of the PicoRV32 mem-to-UI adapter.
- Consumes the adapter's transfer UI: valid/write/read/addr/size/wdata/prot/lock.
- Produces next/ready/rdata/result_addr plus an error pulse.
- Performs bus request, grant, address and data phases, including ERROR/RETRY/SPLIT handling.
- Single transfers only (no bursts); min_len/cont are not ported.

Parameters:
- MAX_RETRY, 15, RETRY/SPLIT re-issues allowed before the transfer is completed as an error (1..15).
- REPLICATE_NARROW, 1, 1: byte writes drive {4{ui_wdata[31:24]}} and halfword writes drive {2{ui_wdata[31:16]}} on hwdata; 0: ui_wdata passes through unchanged.

Ports:
- clk  in  1  clock; all flops rise on posedge.
- resetn  in  1  asynchronous active-low reset.
- ui_valid  in  1  write qualifier.
- ui_write  in  1  write request (ui_valid & ui_write).
- ui_read  in  1  read request; ui_valid is not required for reads.
- ui_addr  in  32  byte address.
- ui_size  in  3  HSIZE encoding: 000 byte, 001 half, 010 word.
- ui_wdata  in  32  write data, big-endian lanes, narrow data MSB-aligned.
- ui_prot  in  4  HPROT.
- ui_lock  in  1  HLOCK request.
- ui_next  out  1  one-cycle pulse: address phase accepted.
- ui_ready  out  1  one-cycle pulse: data phase complete.
- ui_rdata  out  32  captured HRDATA, held until the next read completes.
- ui_result_addr  out  32  address of the last completed transfer.
- ui_err  out  1  one-cycle pulse with ui_ready when the transfer ended in ERROR or exhausted its retries.
- hbusreq  out  1  bus request.
- hlock  out  1  locked request.
- hgrant  in  1  grant.
- htrans  out  2  00 IDLE, 10 NONSEQ only.
- haddr  out  32  address.
- hwrite  out  1  write.
- hsize  out  3  size.
- hburst  out  3  constant 000 (SINGLE).
- hprot  out  4  protection.
- hwdata  out  32  write data.
- hready  in  1  transfer ready.
- hresp  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- hrdata  in  32  read data.

Behaviour:
- Reset values (async, applied while resetn=0, regardless of state):
  - State IDLE.
  - All outputs 0, except htrans=00, hburst=000.
  - ui_rdata=0, ui_result_addr=0, retry counter 0.
- Request condition: req = ui_read | (ui_valid & ui_write). Sampled only in IDLE.
  - On req: latch addr, size, write (=~ui_read), wdata, prot and lock into a command register.
  - hbusreq=1, hlock=lock; go to REQ.
  - If ui_read and ui_write are both high, read wins.
- REQ:
  - Hold hbusreq.
  - When hgrant & hready are sampled high: go to ADDR with htrans=NONSEQ and haddr/hwrite/hsize/hprot from the command register.
- ADDR:
  - Hold NONSEQ until hready is sampled high.
  - Then: ui_next=1 for 1 cycle, htrans=IDLE, drop hbusreq (keep hlock only if lock), drive hwdata, go to DATA.
  - Minimum latency from req to ui_next is 2 cycles with grant parked.
- DATA:
  - hready=1 & hresp=OKAY:
    - For reads, ui_rdata<=hrdata.
    - ui_result_addr<=addr.
    - ui_ready=1 for 1 cycle (reads and writes); go to IDLE.
  - hready=0 & hresp=ERROR (first error cycle): go to ERR2, htrans stays IDLE.
    - ERR2 on hready=1: ui_ready=1, ui_err=1, ui_rdata unchanged; go to IDLE.
  - hready=0 & hresp=RETRY/SPLIT (first cycle): go to RTY2.
    - RTY2 on hready=1: if retry count < MAX_RETRY, increment it, hbusreq=1, go to REQ (re-issue same command).
    - Otherwise complete as in ERR2 with ui_err=1.
  - Retry counter clears on every return to IDLE.
- hwdata is valid only in DATA/ERR2/RTY2; it is zero otherwise.
- REPLICATE_NARROW applies lane replication by latched size; size 010 is always a pass-through.
- No new request is accepted in the cycle ui_ready is asserted: IDLE is entered one cycle later. This guarantees the adapter has dropped read/write before resampling.
- Reset mid-transfer: immediate return to IDLE; no ui_next/ui_ready is emitted; the bus sees htrans=IDLE and hbusreq=0.
- Illegal ui_size (>010): forced to 010.

Decomposition:
- Shared package picorv32_ahb_pkg:
  - HTRANS/HRESP/HSIZE/HBURST constants.
  - FSM state encoding: IDLE, REQ, ADDR, DATA, ERR2, RTY2.
  - MAX_RETRY width.
- Also consumed by the adapter bench.
- No sub-module: single flat FSM plus command register.

Test Plan:
- Word read at 0x4000_0010, hgrant tied 1, hrdata=0xDEADBEEF, zero-wait slave -> ui_next 2 cycles after ui_read; ui_ready 1 cycle later; ui_rdata=0xDEADBEEF; ui_result_addr=0x4000_0010; htrans NONSEQ for exactly one hready cycle.
- Byte write addr 0x8000_0001, ui_wdata=0xA5xxxxxx, REPLICATE_NARROW=1, 2 wait states in data phase -> hsize=000, hwdata=0xA5A5A5A5 during DATA, ui_ready after the third data cycle, ui_err=0.
- hgrant withheld 5 cycles -> hbusreq held high 5 cycles, htrans=IDLE throughout; NONSEQ appears the cycle after hgrant & hready.
- Read with two-cycle ERROR response -> htrans=IDLE in the first error cycle; ui_ready=ui_err=1 in the second; ui_rdata unchanged.
- RETRY answered 16 times with MAX_RETRY=15 -> 16 NONSEQ issues total, then ui_ready=ui_err=1. Separately, RETRY once then OKAY -> 2 issues, ui_err=0.
- resetn pulsed low while in DATA -> all outputs at reset values asynchronously; no ui_ready; a new read after reset completes normally.

Source files
------------

// File: rtl/picorv32_ahb_pkg.sv
// Shared AHB encodings, FSM states and command record for the PicoRV32 AHB master.
// Also imported by the adapter bench.
package picorv32_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Wide enough to count up to the largest legal MAX_RETRY (15).
    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_DATA,
        ST_ERR2,
        ST_RTY2
    } ahb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  prot;
        logic        lock;
    } ahb_cmd_t;

    // Anything wider than a word is treated as a word access.
    function automatic logic [2:0] legal_size(input logic [2:0] size);
        return (size > HSIZE_WORD) ? HSIZE_WORD : size;
    endfunction

    // Narrow write data arrives MSB-aligned; copy it onto every lane when enabled.
    function automatic logic [31:0] lane_data(input logic [2:0]  size,
                                              input logic [31:0] wdata,
                                              input logic        replicate);
        if (!replicate)
            return wdata;
        case (size)
            HSIZE_BYTE: return {4{wdata[31:24]}};
            HSIZE_HALF: return {2{wdata[31:16]}};
            default:    return wdata;
        endcase
    endfunction

endpackage

// File: rtl/picorv32_ahb_master.sv
// Single-outstanding AHB master: takes one UI transfer at a time through
// request/grant, address and data phases, re-issuing on RETRY/SPLIT.
module picorv32_ahb_master
    import picorv32_ahb_pkg::*;
#(
    parameter int MAX_RETRY        = 15,
    parameter bit REPLICATE_NARROW = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ui_valid,
    input  logic        ui_write,
    input  logic        ui_read,
    input  logic [31:0] ui_addr,
    input  logic [2:0]  ui_size,
    input  logic [31:0] ui_wdata,
    input  logic [3:0]  ui_prot,
    input  logic        ui_lock,
    output logic        ui_next,
    output logic        ui_ready,
    output logic [31:0] ui_rdata,
    output logic [31:0] ui_result_addr,
    output logic        ui_err,
    output logic        hbusreq,
    output logic        hlock,
    input  logic        hgrant,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata
);

    ahb_state_e         state;
    ahb_cmd_t           cmd;
    logic [RETRY_W-1:0] retry_cnt;
    logic               req;
    logic               done_ok;
    logic               done_err;

    assign req    = ui_read | (ui_valid & ui_write);
    assign hburst = HBURST_SINGLE;

    // A transfer ends either cleanly in DATA or as an error once the second
    // cycle of an ERROR, or of a RETRY/SPLIT with no retries left, arrives.
    always_comb begin
        done_ok  = 1'b0;
        done_err = 1'b0;
        case (state)
            ST_DATA: begin
                done_ok  = hready && (hresp == HRESP_OKAY);
                done_err = hready && (hresp != HRESP_OKAY);
            end
            ST_ERR2: done_err = hready;
            ST_RTY2: done_err = hready && (retry_cnt >= RETRY_W'(MAX_RETRY));
            default: ;
        endcase
    end

    // NOTE: all state and outputs use non-blocking assignments so every flop
    // samples the same pre-edge values; the command register is reset too so
    // no X ever reaches the bus after an abort.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            cmd            <= '0;
            retry_cnt      <= '0;
            ui_next        <= 1'b0;
            ui_ready       <= 1'b0;
            ui_err         <= 1'b0;
            ui_rdata       <= '0;
            ui_result_addr <= '0;
            hbusreq        <= 1'b0;
            hlock          <= 1'b0;
            htrans         <= HTRANS_IDLE;
            haddr          <= '0;
            hwrite         <= 1'b0;
            hsize          <= '0;
            hprot          <= '0;
            hwdata         <= '0;
        end else begin
            ui_next  <= 1'b0;
            ui_ready <= 1'b0;
            ui_err   <= 1'b0;

            if (done_ok || done_err) begin
                ui_ready  <= 1'b1;
                ui_err    <= done_err;
                hwdata    <= '0;
                hlock     <= 1'b0;
                retry_cnt <= '0;
                state     <= ST_IDLE;
                if (done_ok) begin
                    ui_result_addr <= cmd.addr;
                    if (!cmd.write)
                        ui_rdata <= hrdata;
                end
            end else begin
                case (state)
                    // Skipping the ui_ready cycle gives the adapter time to drop its request.
                    ST_IDLE: begin
                        if (req && !ui_ready) begin
                            cmd.addr  <= ui_addr;
                            cmd.size  <= legal_size(ui_size);
                            cmd.write <= ~ui_read;
                            cmd.wdata <= ui_wdata;
                            cmd.prot  <= ui_prot;
                            cmd.lock  <= ui_lock;
                            hbusreq   <= 1'b1;
                            hlock     <= ui_lock;
                            state     <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (hgrant && hready) begin
                            htrans <= HTRANS_NONSEQ;
                            haddr  <= cmd.addr;
                            hwrite <= cmd.write;
                            hsize  <= cmd.size;
                            hprot  <= cmd.prot;
                            state  <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (hready) begin
                            ui_next <= 1'b1;
                            htrans  <= HTRANS_IDLE;
                            hbusreq <= 1'b0;
                            hlock   <= cmd.lock;
                            hwdata  <= lane_data(cmd.size, cmd.wdata, REPLICATE_NARROW);
                            state   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (hresp == HRESP_ERROR)
                            state <= ST_ERR2;
                        else if (hresp[1])
                            state <= ST_RTY2;
                    end
                    ST_ERR2: ;
                    ST_RTY2: begin
                        // Only reached with retries left; done_err covers exhaustion.
                        if (hready) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            hbusreq   <= 1'b1;
                            hwdata    <= '0;
                            state     <= ST_REQ;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_picorv32_ahb_master.sv
// Randomized bench for picorv32_ahb_master: an AHB slave/arbiter model plus a
// transaction-level reference that predicts issue count, latency and results.
module tb_picorv32_ahb_master;

    localparam int MAX_RETRY = 15;

    logic        clk;
    logic        resetn;
    logic        ui_valid, ui_write, ui_read, ui_lock;
    logic [31:0] ui_addr, ui_wdata;
    logic [2:0]  ui_size;
    logic [3:0]  ui_prot;
    logic        ui_next, ui_ready, ui_err;
    logic [31:0] ui_rdata, ui_result_addr;
    logic        hbusreq, hlock, hgrant, hwrite, hready;
    logic [1:0]  htrans, hresp;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_rdata;
    logic [31:0] m_result_addr;

    picorv32_ahb_master #(.MAX_RETRY(MAX_RETRY), .REPLICATE_NARROW(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .ui_valid(ui_valid), .ui_write(ui_write), .ui_read(ui_read),
        .ui_addr(ui_addr), .ui_size(ui_size), .ui_wdata(ui_wdata),
        .ui_prot(ui_prot), .ui_lock(ui_lock),
        .ui_next(ui_next), .ui_ready(ui_ready), .ui_rdata(ui_rdata),
        .ui_result_addr(ui_result_addr), .ui_err(ui_err),
        .hbusreq(hbusreq), .hlock(hlock), .hgrant(hgrant), .htrans(htrans),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hwdata(hwdata), .hready(hready), .hresp(hresp),
        .hrdata(hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drop_request();
        ui_read  = 1'b0;
        ui_write = 1'b0;
        ui_valid = 1'b0;
        ui_lock  = 1'b0;
    endtask

    // Runs one UI transfer from a negedge. kind: 0 OKAY, 1 ERROR, 2 RETRY/SPLIT
    // answered n_retry times before OKAY.
    task automatic run_txn(input bit rd, input bit both, input bit lock,
                           input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, input logic [3:0] prot,
                           input int gnt_wait, input int waits, input int kind,
                           input int n_retry, input bit split, input logic [31:0] rdata);
        int          cyc = 0, issues = 0, req_cycles = 0, first_req = -1;
        int          first_next = -1, last_next = -1, ready_seen = 0, k = 0;
        bit          dp = 1'b0, done = 1'b0;
        logic [1:0]  cur_resp = 2'b00;
        logic [2:0]  exp_size;
        logic [31:0] exp_hw;
        int          exp_issues;
        bit          exp_err;

        exp_size = (size > 3'd2) ? 3'd2 : size;
        case (exp_size)
            3'd0:    exp_hw = (wdata >> 24) * 32'h0101_0101;
            3'd1:    exp_hw = (wdata >> 16) * 32'h0001_0001;
            default: exp_hw = wdata;
        endcase
        if (kind == 2) begin
            exp_issues = ((n_retry > MAX_RETRY) ? MAX_RETRY : n_retry) + 1;
            exp_err    = (n_retry > MAX_RETRY);
        end else begin
            exp_issues = 1;
            exp_err    = (kind == 1);
        end

        ui_read  = rd;
        ui_write = !rd || both;
        ui_valid = !rd || both;
        ui_lock  = lock;
        ui_addr  = addr;
        ui_size  = size;
        ui_wdata = wdata;
        ui_prot  = prot;
        hgrant   = (gnt_wait == 0);
        hready   = 1'b1;
        hresp    = 2'b00;

        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ready_seen > 0) begin
                check("ready_pulse", ui_ready, 1'b0);
                check("no_reaccept", hbusreq, 1'b0);
                check("hwdata_idle", hwdata, 32'h0);
                drop_request();
                done = 1'b1;
            end else begin
                if (ui_next) begin
                    if (first_next < 0) first_next = cyc;
                    last_next = cyc;
                end
                if (ui_ready) begin
                    ready_seen++;
                    check("err", ui_err, exp_err);
                    if (!exp_err) begin
                        m_result_addr = addr;
                        if (rd) m_rdata = rdata;
                    end
                    check("rdata", ui_rdata, m_rdata);
                    check("result_addr", ui_result_addr, m_result_addr);
                    check("issues", issues, exp_issues);
                    check("data_len", cyc - last_next, exp_err ? waits + 2 : waits + 1);
                    check("next_latency", first_next, 3 + gnt_wait);
                    check("req_cycles", first_req, gnt_wait + 1);
                end

                hrdata = $urandom;
                if (dp) begin
                    if (k == 0 && issues == 1) begin
                        check("dp_htrans", htrans, 2'b00);
                        if (!rd) check("hwdata", hwdata, exp_hw);
                    end
                    if (k < waits) begin
                        hready = 1'b0; hresp = 2'b00;
                    end else if (cur_resp == 2'b00) begin
                        hready = 1'b1; hresp = 2'b00; hrdata = rdata; dp = 1'b0;
                    end else if (k == waits) begin
                        hready = 1'b0; hresp = cur_resp;
                    end else begin
                        hready = 1'b1; hresp = cur_resp; dp = 1'b0;
                    end
                    k++;
                end else if (htrans == 2'b10) begin
                    issues++;
                    if (issues == 1) begin
                        first_req = req_cycles;
                        check("addr_phase", {haddr, hprot, hsize, hwrite, hlock},
                              {addr, prot, exp_size, !rd, lock});
                    end
                    req_cycles = 0;
                    hready     = 1'b1;
                    hresp      = 2'b00;
                    dp         = 1'b1;
                    k          = 0;
                    if (kind == 1)
                        cur_resp = 2'b01;
                    else if (kind == 2 && issues <= n_retry)
                        cur_resp = split ? 2'b11 : 2'b10;
                    else
                        cur_resp = 2'b00;
                end else begin
                    if (hbusreq) req_cycles++;
                    hready = 1'b1;
                    hresp  = 2'b00;
                end
                hgrant = (gnt_wait == 0) || (req_cycles > gnt_wait);
            end
        end
        if (!done) begin
            check("timeout", 1'b1, 1'b0);
            drop_request();
        end
        hgrant = 1'b1;
        hready = 1'b1;
        hresp  = 2'b00;
    endtask

    initial begin
        bit seen;
        resetn   = 1'b0;
        drop_request();
        ui_addr  = '0;
        ui_size  = '0;
        ui_wdata = '0;
        ui_prot  = '0;
        hgrant   = 1'b1;
        hready   = 1'b1;
        hresp    = 2'b00;
        hrdata   = '0;
        m_rdata       = '0;
        m_result_addr = '0;

        repeat (3) @(negedge clk);
        check("rst_ui", {ui_rdata, ui_result_addr}, 64'h0);
        check("rst_bus", {haddr, hwdata}, 64'h0);
        check("rst_ctl", {ui_next, ui_ready, ui_err, hbusreq, hlock, htrans, hwrite, hsize, hburst, hprot}, 64'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed cases
        run_txn(1, 0, 0, 32'h4000_0010, 3'b010, 32'h0, 4'h3, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        run_txn(0, 0, 0, 32'h8000_0001, 3'b000, 32'hA512_3456, 4'h1, 0, 2, 0, 0, 0, 32'h1111_2222);
        run_txn(1, 0, 0, 32'h0000_0100, 3'b010, 32'h0, 4'h0, 5, 0, 0, 0, 0, 32'h0BAD_F00D);
        run_txn(1, 0, 0, 32'h0000_0200, 3'b010, 32'h0, 4'h0, 0, 0, 1, 0, 0, 32'h5555_AAAA);
        run_txn(0, 0, 0, 32'h0000_0300, 3'b010, 32'h1234_5678, 4'h2, 0, 0, 2, 16, 0, 32'h0);
        run_txn(1, 0, 0, 32'h0000_0400, 3'b010, 32'h0, 4'h2, 0, 0, 2, 1, 0, 32'hCAFE_0001);
        run_txn(1, 1, 1, 32'h0000_0502, 3'b001, 32'hBEEF_0000, 4'hF, 1, 1, 0, 0, 0, 32'h7777_8888);
        run_txn(0, 0, 0, 32'h0000_0602, 3'b001, 32'hBEEF_1234, 4'h1, 0, 0, 2, 2, 1, 32'h0);
        run_txn(0, 0, 0, 32'h0000_0700, 3'b100, 32'h89AB_CDEF, 4'h1, 0, 1, 0, 0, 0, 32'h0);

        // Reset while the data phase is stalled
        @(negedge clk);
        ui_read = 1'b1;
        ui_addr = 32'h1234_5678;
        ui_size = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ui_next) seen = 1'b1;
        end
        check("rst_reach_data", seen, 1'b1);
        hready = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_ui", {ui_rdata, ui_result_addr}, 64'h0);
        check("arst_bus", {haddr, hwdata}, 64'h0);
        check("arst_ctl", {ui_next, ui_ready, ui_err, hbusreq, hlock, htrans, hwrite, hsize, hburst, hprot}, 64'h0);
        drop_request();
        hready = 1'b1;
        hrdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("arst_no_ready", {ui_ready, hbusreq, htrans}, 64'h0);
        resetn = 1'b1;
        m_rdata       = '0;
        m_result_addr = '0;
        run_txn(1, 0, 0, 32'h2000_0040, 3'b010, 32'h0, 4'h3, 0, 0, 0, 0, 0, 32'h600D_CAFE);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int          kind, nr;
            bit          rd;
            logic [31:0] rnd_addr;
            logic [2:0]  rnd_size;
            rd       = $urandom_range(0, 1);
            kind     = $urandom_range(0, 3);
            nr       = $urandom_range(1, 3);
            rnd_addr = $urandom;
            rnd_size = 3'($urandom_range(0, 4));
            if (kind == 3) kind = 0;
            run_txn(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr, rnd_size,
                    $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    kind, (kind == 2) ? nr : 0, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
